// File: rtl/serial_work_sender.sv
// ---------------------------------------------------------------------------
// serial_work_sender
//
// Host-side master of the miner's clocked serial link. Shifts one 512-bit
// work unit ({midstate, data2}, MSB first) out on RxD with a generated RxC,
// owns the shared link reset RxTxR, generates the free-running nonce clock
// TxC and deserialises 32-bit golden nonces returned on TxD.
//
// Ports
//   clk, reset_n          system clock (rising edge), async active-low reset
//   work_valid/work_ready work hand-off; accept when both are high
//   midstate, data2       work unit, sampled on accept
//   link_reset_req        1-cycle pulse: abort everything, re-run link reset
//   RxD, RxC              serial work data / clock to the miner
//   RxTxR                 link reset to the miner, active high
//   TxC, TxD              serial nonce clock to / data from the miner
//   nonce_valid, nonce    1-cycle pulse with the received nonce (nonce held)
//   busy                  high while shifting a frame or in link reset
//   dbg_tx_state          transmit FSM state (0 LINK_RST, 1 IDLE, 2 SHIFT)
//   dbg_rx_state          receive FSM state (0 RX_IDLE, 1 RX_DATA)
//
// Handshake: work_valid/work_ready follow valid/ready semantics; a transfer
// happens on a rising clk edge where both are high. work_ready is high only
// in IDLE, and link_reset_req on the same cycle wins over the transfer.
// ---------------------------------------------------------------------------
module serial_work_sender #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned RESET_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] midstate,
    input  logic [255:0] data2,
    input  logic         link_reset_req,
    output logic         RxD,
    output logic         RxC,
    output logic         RxTxR,
    output logic         TxC,
    input  logic         TxD,
    output logic         nonce_valid,
    output logic [31:0]  nonce,
    output logic         busy,
    output logic [1:0]   dbg_tx_state,
    output logic         dbg_rx_state
);

    localparam int unsigned RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        TX_LINK_RST = 2'd0,
        TX_IDLE     = 2'd1,
        TX_SHIFT    = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_DATA = 1'b1
    } rx_state_e;

    // Transmit side
    tx_state_e        tx_state_q, tx_state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [7:0]       rxdiv_q, rxdiv_d;
    logic             rxc_q, rxc_d;
    logic             rxd_q, rxd_d;
    logic [511:0]     shreg_q, shreg_d;
    logic [9:0]       fall_cnt_q, fall_cnt_d;

    // Nonce clock
    logic [7:0]       txdiv_q, txdiv_d;
    logic             txc_q, txc_d;

    // Receive side
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    rx_state_e        rx_state_q, rx_state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      nonce_q, nonce_d;
    logic             nonce_valid_q, nonce_valid_d;

    logic             rxdiv_tc;
    logic             txc_run;
    logic             tx_sample;

    assign rxdiv_tc = (rxdiv_q == DIV_LAST);
    assign txc_run  = (tx_state_q != TX_LINK_RST);
    // The TxC high->low cycle is the nonce sample point.
    assign tx_sample = txc_run && txc_q && (txdiv_q == DIV_LAST) && !link_reset_req;

    // ---------------- transmit FSM ----------------
    always_comb begin
        tx_state_d = tx_state_q;
        rst_cnt_d  = rst_cnt_q;
        rxdiv_d    = rxdiv_q;
        rxc_d      = rxc_q;
        rxd_d      = rxd_q;
        shreg_d    = shreg_q;
        fall_cnt_d = fall_cnt_q;

        case (tx_state_q)
            TX_LINK_RST: begin
                rxc_d      = 1'b0;
                rxd_d      = 1'b0;
                rxdiv_d    = 8'd0;
                fall_cnt_d = 10'd0;
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d  = '0;
                    tx_state_d = TX_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            TX_IDLE: begin
                rxc_d = 1'b0;
                rxd_d = 1'b0;
                if (work_valid) begin
                    shreg_d    = {midstate, data2};
                    rxd_d      = midstate[255];
                    rxdiv_d    = 8'd0;
                    fall_cnt_d = 10'd0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (fall_cnt_q == 10'd512) begin
                    // One trailing cycle after the last falling edge
                    // completes the 1024*CLK_DIV+1 frame.
                    tx_state_d = TX_IDLE;
                end else if (rxdiv_tc) begin
                    rxdiv_d = 8'd0;
                    rxc_d   = ~rxc_q;
                    if (rxc_q) begin
                        // Falling edge of RxC: present the next bit.
                        shreg_d    = {shreg_q[510:0], 1'b0};
                        fall_cnt_d = fall_cnt_q + 10'd1;
                        rxd_d      = (fall_cnt_q == 10'd511) ? 1'b0 : shreg_q[510];
                    end
                end else begin
                    rxdiv_d = rxdiv_q + 8'd1;
                end
            end
            default: begin
                tx_state_d = TX_LINK_RST;
                rst_cnt_d  = '0;
            end
        endcase

        if (link_reset_req) begin
            tx_state_d = TX_LINK_RST;
            rst_cnt_d  = '0;
            rxc_d      = 1'b0;
            rxd_d      = 1'b0;
            rxdiv_d    = 8'd0;
            fall_cnt_d = 10'd0;
        end
    end

    // ---------------- nonce clock ----------------
    always_comb begin
        txdiv_d = txdiv_q;
        txc_d   = txc_q;
        if (!txc_run || link_reset_req) begin
            txdiv_d = 8'd0;
            txc_d   = 1'b0;
        end else if (txdiv_q == DIV_LAST) begin
            txdiv_d = 8'd0;
            txc_d   = ~txc_q;
        end else begin
            txdiv_d = txdiv_q + 8'd1;
        end
    end

    // ---------------- receive FSM ----------------
    always_comb begin
        sync1_d       = TxD;
        sync2_d       = sync1_q;
        rx_state_d    = rx_state_q;
        bit_cnt_d     = bit_cnt_q;
        word_d        = word_q;
        nonce_d       = nonce_q;
        nonce_valid_d = 1'b0;

        if (tx_sample) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!sync2_q) begin
                        rx_state_d = RX_DATA;
                        bit_cnt_d  = 5'd0;
                    end
                end
                RX_DATA: begin
                    word_d    = {word_q[30:0], sync2_q};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        nonce_d       = {word_q[30:0], sync2_q};
                        nonce_valid_d = 1'b1;
                        rx_state_d    = RX_IDLE;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end

        // Link reset drops any partial word; the last nonce is kept.
        if (!txc_run || link_reset_req) begin
            rx_state_d    = RX_IDLE;
            bit_cnt_d     = 5'd0;
            word_d        = 32'd0;
            nonce_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q    <= TX_LINK_RST;
            rst_cnt_q     <= '0;
            rxdiv_q       <= 8'd0;
            rxc_q         <= 1'b0;
            rxd_q         <= 1'b0;
            shreg_q       <= '0;
            fall_cnt_q    <= 10'd0;
            txdiv_q       <= 8'd0;
            txc_q         <= 1'b0;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_state_q    <= RX_IDLE;
            bit_cnt_q     <= 5'd0;
            word_q        <= 32'd0;
            nonce_q       <= 32'd0;
            nonce_valid_q <= 1'b0;
        end else begin
            tx_state_q    <= tx_state_d;
            rst_cnt_q     <= rst_cnt_d;
            rxdiv_q       <= rxdiv_d;
            rxc_q         <= rxc_d;
            rxd_q         <= rxd_d;
            shreg_q       <= shreg_d;
            fall_cnt_q    <= fall_cnt_d;
            txdiv_q       <= txdiv_d;
            txc_q         <= txc_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_state_q    <= rx_state_d;
            bit_cnt_q     <= bit_cnt_d;
            word_q        <= word_d;
            nonce_q       <= nonce_d;
            nonce_valid_q <= nonce_valid_d;
        end
    end

    assign work_ready   = (tx_state_q == TX_IDLE);
    assign busy         = (tx_state_q != TX_IDLE);
    assign RxTxR        = (tx_state_q == TX_LINK_RST);
    assign RxC          = rxc_q;
    assign RxD          = rxd_q;
    assign TxC          = txc_q;
    assign nonce        = nonce_q;
    assign nonce_valid  = nonce_valid_q;
    assign dbg_tx_state = tx_state_q;
    assign dbg_rx_state = rx_state_q;

endmodule

// File: tb/tb_serial_work_sender.sv
// ---------------------------------------------------------------------------
// tb_serial_work_sender
//
// Drives serial_work_sender (CLK_DIV=4, RESET_CYCLES=16) with a table of work
// frames plus hand-written sequences for link reset and async reset. A miner
// model captures RxD on RxC rising edges and returns nonces on TxD, changing
// data after each TxC rising edge. Received nonces are scored against an
// expected queue.
// ---------------------------------------------------------------------------
module tb_serial_work_sender;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         work_valid;
    logic         work_ready;
    logic [255:0] midstate;
    logic [255:0] data2;
    logic         link_reset_req;
    logic         RxD, RxC, RxTxR, TxC, TxD;
    logic         nonce_valid;
    logic [31:0]  nonce;
    logic         busy;
    logic [1:0]   dbg_tx_state;
    logic         dbg_rx_state;

    serial_work_sender #(.CLK_DIV(4), .RESET_CYCLES(16)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .work_valid     (work_valid),
        .work_ready     (work_ready),
        .midstate       (midstate),
        .data2          (data2),
        .link_reset_req (link_reset_req),
        .RxD            (RxD),
        .RxC            (RxC),
        .RxTxR          (RxTxR),
        .TxC            (TxC),
        .TxD            (TxD),
        .nonce_valid    (nonce_valid),
        .nonce          (nonce),
        .busy           (busy),
        .dbg_tx_state   (dbg_tx_state),
        .dbg_rx_state   (dbg_rx_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- miner model: frame capture ----------------
    logic [511:0] cap_bits = '0;
    int           cap_cnt  = 0;
    logic         prev_rxc = 1'b0;
    always @(negedge clk) begin
        if (prev_rxc === 1'b0 && RxC === 1'b1) begin
            cap_bits = {cap_bits[510:0], RxD};
            cap_cnt++;
        end
        prev_rxc = RxC;
    end

    // ---------------- miner model: nonce driver ----------------
    logic [31:0] send_q[$];
    initial begin
        logic [31:0] m_word;
        int          m_left;
        logic        m_active;
        logic        prev_txc;
        TxD      = 1'b1;
        m_word   = '0;
        m_left   = 0;
        m_active = 1'b0;
        prev_txc = 1'b0;
        forever begin
            @(negedge clk);
            if (RxTxR !== 1'b0) begin
                TxD      = 1'b1;
                m_active = 1'b0;
                send_q.delete();
            end else if (prev_txc === 1'b0 && TxC === 1'b1) begin
                if (m_active) begin
                    TxD = m_word[m_left-1];
                    m_left--;
                    if (m_left == 0) m_active = 1'b0;
                end else if (send_q.size() > 0) begin
                    m_word   = send_q.pop_front();
                    m_left   = 32;
                    m_active = 1'b1;
                    TxD      = 1'b0;
                end else begin
                    TxD = 1'b1;
                end
            end
            prev_txc = TxC;
        end
    end

    // ---------------- scoreboard: nonces ----------------
    logic [31:0] exp_q[$];
    int          nonce_pulses = 0;
    logic        prev_nv = 1'b0;
    always @(negedge clk) begin
        if (prev_nv) check("nonce_valid_width", nonce_valid, 1'b0);
        if (nonce_valid === 1'b1) begin
            nonce_pulses++;
            if (exp_q.size() > 0) check("nonce_value", nonce, exp_q.pop_front());
            else check("nonce_unexpected", nonce_valid, 1'b0);
        end
        prev_nv = (nonce_valid === 1'b1);
    end

    // ---------------- driver tasks ----------------
    int acc_cyc;
    int cap_start;

    task automatic check_link_reset(input string name);
        // Called at the first observed LINK_RST cycle.
        check(name, {RxTxR, work_ready, RxC, TxC, RxD, busy}, 6'b100001);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check(name, {RxTxR, work_ready, RxC, TxC, RxD, busy}, 6'b100001);
        end
        @(negedge clk);
        check({name, "_end"}, {RxTxR, work_ready, busy}, 3'b010);
    endtask

    task automatic send_work(input logic [255:0] ms, input logic [255:0] d2);
        midstate   = ms;
        data2      = d2;
        work_valid = 1'b1;
        cap_start  = cap_cnt;
        @(negedge clk);
        acc_cyc = cyc;
        // Keep valid asserted with other data: SHIFT must ignore it.
        midstate = ~ms;
        data2    = ~d2;
        repeat (20) @(negedge clk);
        work_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, output int len);
        int n = 0;
        while (work_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        len = cyc - acc_cyc;
        check({name, "_ready_timeout"}, work_ready, 1'b1);
    endtask

    task automatic wait_bits(input int target, input string name);
        int n = 0;
        while ((cap_cnt - cap_start) < target && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check(name, (cap_cnt - cap_start) >= target, 1'b1);
    endtask

    task automatic wait_nonces(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [255:0] ms;
        logic [255:0] d2;
        int           n_nonce;
        logic [31:0]  n0;
        logic [31:0]  n1;
        int           exp_len;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int          len;
        int          pulses0;
        logic [31:0] last_nonce;

        vecs[0] = '{256'h2b3f81f8_4e1a5b6c_9d0e7f32_a4b5c6d7_e8f90a1b_2c3d4e5f_60718293_a4b5c0b5,
                    256'h00000000_00000000_00000000_00000000_80000000_39f3001b_6b7b8d4d_c14bfc31,
                    1, 32'h01D01BDC, 32'h0, 4097};
        vecs[1] = '{256'ha5a5a5a5_5a5a5a5a_ffffffff_00000000_12345678_9abcdef0_0f0f0f0f_f0f0f0f0,
                    256'h01234567_89abcdef_fedcba98_76543210_c3c3c3c3_3c3c3c3c_deadbeef_00000001,
                    2, 32'hFFFFFFFF, 32'h00000000, 4097};
        vecs[2] = '{256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000001,
                    256'hffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_fffffffe,
                    1, 32'h80000001, 32'h0, 4097};

        reset_n        = 1'b0;
        work_valid     = 1'b0;
        link_reset_req = 1'b0;
        midstate       = '0;
        data2          = '0;
        last_nonce     = 32'h0;

        // Reset values, then power-up link reset.
        repeat (3) @(negedge clk);
        check("reset_values",
              {RxTxR, RxC, RxD, TxC, work_ready, busy, nonce_valid, nonce},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
        reset_n = 1'b1;
        check_link_reset("power_up_link_rst");

        // Work frames with nonces arriving during SHIFT.
        for (int v = 0; v < 3; v++) begin
            pulses0 = nonce_pulses;
            send_q.push_back(vecs[v].n0);
            exp_q.push_back(vecs[v].n0);
            last_nonce = vecs[v].n0;
            if (vecs[v].n_nonce == 2) begin
                send_q.push_back(vecs[v].n1);
                exp_q.push_back(vecs[v].n1);
                last_nonce = vecs[v].n1;
            end
            send_work(vecs[v].ms, vecs[v].d2);
            wait_ready("frame", len);
            check("frame_len", len, vecs[v].exp_len);
            check("frame_edges", cap_cnt - cap_start, 512);
            check("frame_bits", cap_bits, {vecs[v].ms, vecs[v].d2});
            check("frame_idle_lines", {RxC, RxD, busy}, 3'b000);
            wait_nonces("nonce_drain");
            check("nonce_count", nonce_pulses - pulses0, vecs[v].n_nonce);
            repeat (40) @(negedge clk);
            check("nonce_hold", nonce, last_nonce);
        end

        // link_reset_req at bit 200 with valid high; nonce in flight is dropped.
        pulses0 = nonce_pulses;
        send_work(vecs[1].ms, vecs[1].d2);
        wait_bits(185, "wait_bit185");
        send_q.push_back(32'hDEADBEEF);
        wait_bits(200, "wait_bit200");
        link_reset_req = 1'b1;
        work_valid     = 1'b1;
        midstate       = 256'h1;
        data2          = 256'h2;
        @(negedge clk);
        link_reset_req = 1'b0;
        work_valid     = 1'b0;
        check_link_reset("abort_link_rst");
        check("abort_edges", cap_cnt - cap_start, 200);
        check("abort_nonce_kept", nonce, last_nonce);
        check("abort_no_nonce", nonce_pulses - pulses0, 0);

        // link_reset_req wins over a simultaneous accept in IDLE.
        repeat (3) @(negedge clk);
        link_reset_req = 1'b1;
        work_valid     = 1'b1;
        @(negedge clk);
        link_reset_req = 1'b0;
        work_valid     = 1'b0;
        check_link_reset("priority_link_rst");
        repeat (20) @(negedge clk);
        check("priority_no_frame", {RxC, work_ready}, 2'b01);

        // Stand-alone nonce after the abort: partial word must be gone.
        pulses0 = nonce_pulses;
        send_q.push_back(32'h13579BDF);
        exp_q.push_back(32'h13579BDF);
        last_nonce = 32'h13579BDF;
        wait_nonces("idle_nonce_drain");
        check("idle_nonce_count", nonce_pulses - pulses0, 1);
        repeat (60) @(negedge clk);
        check("idle_nonce_hold", nonce, last_nonce);

        // Asynchronous reset in the middle of a frame, with RxC high.
        send_work(vecs[0].ms, vecs[0].d2);
        wait_bits(50, "wait_bit50");
        begin
            int n = 0;
            while (RxC !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("pre_reset_rxc_high", RxC, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {RxD, RxC, TxC, work_ready, RxTxR, busy, nonce_valid, nonce},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0});
        @(negedge clk);
        reset_n = 1'b1;
        check_link_reset("reset_release_link_rst");

        // Receive path after reset.
        send_q.push_back(32'hA5A50F0F);
        exp_q.push_back(32'hA5A50F0F);
        wait_nonces("post_reset_nonce_drain");
        check("post_reset_nonce", nonce, 32'hA5A50F0F);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_work_sender.md
Name: serial_work_sender

Overview:
Host-side master for the miner's clocked serial link, and the opposite end of the on-FPGA serial_receive/serial_transmit pair. It shifts one 512-bit work unit (midstate, then data2) out on RxD with a generated RxC, and owns the shared link reset RxTxR. It also generates TxC and deserialises 32-bit golden nonces returned on TxD. It sits in the controller/test FPGA that feeds one or more Bee2 mining FPGAs.

Parameters:
CLK_DIV, 4, clk cycles per half-period of RxC and TxC; legal range 3..255.
RESET_CYCLES, 16, clk cycles RxTxR is held high after reset release or link_reset_req; minimum 1.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
reset_n  input  1  asynchronous active-low reset.
work_valid  input  1  work unit is presented on midstate and data2.
work_ready  output  1  block accepts work; the transfer occurs when valid and ready are both high.
midstate  input  256  midstate of the work unit; sampled on accept.
data2  input  256  second data block of the work unit; sampled on accept.
link_reset_req  input  1  1-cycle pulse that aborts all activity and re-runs the link reset.
RxD  output  1  serial work data to the miner.
RxC  output  1  serial work clock to the miner.
RxTxR  output  1  link reset to the miner; active high.
TxC  output  1  serial nonce clock to the miner.
TxD  input  1  serial nonce data from the miner; asynchronous to clk.
nonce_valid  output  1  1-cycle pulse when a nonce is complete.
nonce  output  32  last received nonce; held until the next nonce_valid.
busy  output  1  high while a work frame is shifting or the link is in reset.

Behaviour:
- Reset (reset_n low) values: RxTxR=1, RxC=0, RxD=0, TxC=0, work_ready=0, busy=1, nonce_valid=0, nonce=0. Both FSMs are cleared.
- Transmit FSM has three states: LINK_RST, IDLE, SHIFT.
- LINK_RST: RxTxR=1, RxC=0, TxC=0, RxD=0. It lasts exactly RESET_CYCLES clk cycles, then moves to IDLE.
  - LINK_RST is entered after reset release and on any cycle where link_reset_req=1, from any state.
  - link_reset_req takes priority over a simultaneous accept.
- IDLE: work_ready=1, busy=0, RxTxR=0, RxC=0.
  - On accept, load a 512-bit shift register with {midstate, data2}, drive RxD=midstate[255] on the next cycle, and go to SHIFT.
- SHIFT: work_ready=0, busy=1.
  - A divider counts 0..CLK_DIV-1. At the terminal count RxC toggles.
  - Each RxC rising edge is the miner's sample point.
  - Each RxC falling edge is followed in the same cycle by RxD advancing to the next bit, MSB first. Order is midstate[255..0], then data2[255..0].
  - After the 512th falling edge: RxD=0, RxC=0, return to IDLE.
  - Frame length from accept to work_ready high is exactly 1024*CLK_DIV+1 cycles.
  - work_valid during SHIFT is ignored.
- TxC: free-running toggle every CLK_DIV cycles whenever the FSM is not in LINK_RST. It uses its own divider and restarts low when LINK_RST ends.
- Nonce receive path:
  - TxD passes through a 2-flop synchroniser.
  - The synchronised value is sampled on the clk cycle where TxC goes high to low. This gives CLK_DIV-2 cycles of settling after the miner updates TxD on the rising edge of TxC.
  - Receive states are RX_IDLE and RX_DATA.
  - RX_IDLE: wait for a sampled 0 (start bit). The idle line is 1.
  - RX_DATA: collect 32 samples MSB first. On the 32nd sample, load nonce, pulse nonce_valid for one cycle, and return to RX_IDLE.
  - No stop bit is required; the next start bit may follow immediately.
- LINK_RST clears the receive FSM and any partial word. The nonce register keeps its value; nonce_valid=0.
- The receive path runs independently of the transmit FSM, so nonces can arrive during SHIFT.
- reset_n asserted mid-frame or mid-nonce: outputs go to reset values immediately, and the partial frame or word is discarded.

Test Plan:
1. Reset, then release -> RxTxR=1 for 16 cycles, work_ready rises in cycle 17, RxC=TxC=0 throughout LINK_RST.
2. CLK_DIV=4; accept midstate=256'h2b3f...c0b5, data2=256'h...39f3001b6b7b8d4dc14bfc31 -> 512 RxC rising edges; bits captured on those edges equal {midstate, data2} MSB first; work_ready high again 4097 cycles after accept.
3. Miner model drives start bit 0 followed by 32'h01D01BDC on TxC rising edges -> exactly one nonce_valid pulse with nonce=32'h01D01BDC; nonce holds afterwards.
4. Two back-to-back nonces (32'hFFFFFFFF, 32'h00000000) with no idle gap -> two nonce_valid pulses carrying the correct values, with a nonce arriving during an active SHIFT frame.
5. link_reset_req pulse at bit 200 of a frame, with work_valid high in the same cycle -> RxTxR=1 for 16 cycles; frame aborted; no accept; partial nonce discarded; IDLE afterwards.
6. reset_n low mid-frame -> RxD, RxC, TxC, work_ready = 0 and RxTxR=1 immediately, without waiting for a clock edge.
